pipe_rate_change_ctrl: RTL and testbench
========================================

// Module: pipe_rate_change_ctrl
// PURPOSE
//  PIPE rate/PCLK change sequencer between mainLTSSM and the PHY. On a speed-change request from the
//  LTSSM it forces Tx electrical idle, drives Rate/PCLKRate/width, runs the PclkChangeOk/PclkChangeAck
//  handshake and waits for PhyStatus on every active lane. It then reports completion or timeout.
//  It owns the PCIe top-level Rate, PCLKRate, PclkChangeAck and width outputs.
// PARAMETERS
//  LANESNUMBER     16    lanes on PIPE
//  MAX_GEN         1     highest supported generation (1..5)
//  GEN1..GEN5_PIPEWIDTH 8 per-gen PIPE data width (8/16/32)
//  EIDLE_CYCLES    8     pclk cycles TxElecIdle is held before Rate changes
//  TIMEOUT_CYCLES  4096  max cycles waiting for PclkChangeOk, and again for PhyStatus
// PORTS
//  pclk            in   1   clock
//  reset_n         in   1   asynchronous active-low reset
//  rate_req        in   1   1-cycle pulse from LTSSM: start change to target_gen
//  target_gen      in   3   requested generation 1..5, sampled with rate_req
//  lane_mask       in   LANESNUMBER  active lanes, sampled with rate_req
//  PclkChangeOk    in   1   PHY ready for new PCLK
//  PhyStatus       in   LANESNUMBER  per-lane PHY completion
//  Rate            out  4   PIPE Rate = cur_gen-1
//  PCLKRate        out  5   PIPE PCLKRate = cur_gen-1
//  PclkChangeAck   out  1   handshake ack to PHY
//  width           out  2   PIPE width: 8->0, 16->1, 32->2, for cur_gen
//  tx_eidle_req    out  1   forces TxElecIdle on all lanes; ORed with TX path
//  busy            out  1   high from accept to done/error
//  rate_done       out  1   1-cycle pulse: change complete
//  rate_error      out  1   1-cycle pulse: illegal request or timeout
//  cur_gen         out  3   committed generation, goes to pl_speedmode/GEN
// BEHAVIOUR
//  Reset values:
//   - cur_gen=1, Rate=0, PCLKRate=0, width=enc(GEN1_PIPEWIDTH), all other outputs 0, state IDLE.
//   - Reset mid-sequence aborts immediately to these values.
//  FSM:
//   - IDLE: on rate_req latch tgt and mask.
//     - tgt==0 or tgt>MAX_GEN: rate_error next cycle, stay IDLE.
//     - tgt==cur_gen: rate_done next cycle, no PHY handshake.
//     - Otherwise busy=1, go EIDLE.
//     - If mask==0, lane 0 is required.
//   - EIDLE: tx_eidle_req=1; count EIDLE_CYCLES, then SETRATE.
//   - SETRATE: Rate/PCLKRate/width drive tgt values, with prev_gen saved. Wait for PclkChangeOk, then ACK.
//   - ACK: PclkChangeAck=1.
//     - Sticky per-lane PhyStatus bits are cleared on entry.
//     - When (sticky|~mask)==all-ones, go DONE.
//   - DONE: cur_gen<=tgt; PclkChangeAck, tx_eidle_req, busy drop; rate_done pulses; go IDLE.
//  Latency: a legal change with Ok/PhyStatus already high completes in EIDLE_CYCLES+3 cycles after rate_req.
//  Handshake rules:
//   - PhyStatus seen outside ACK is ignored.
//   - PclkChangeOk is only sampled in SETRATE.
//   - rate_req while busy is ignored, with no error.
//  Timeout: separate counters in SETRATE and ACK; either reaching TIMEOUT_CYCLES causes:
//   - PclkChangeAck=0, Rate/PCLKRate/width restored to prev_gen, cur_gen unchanged;
//   - rate_error pulse, busy=0, go IDLE.
//  Counters saturate and never wrap. PhyStatus on multiple lanes in the same cycle all count.
//  tx_eidle_req stays high through EIDLE/SETRATE/ACK and drops in the DONE cycle.
// TESTING
//  - Reset: assert reset_n=0 mid-ACK -> Rate=0, PclkChangeAck=0, busy=0, cur_gen=1 immediately.
//  - Legal 1->2 (MAX_GEN=2), mask=16'h000F, Ok after 5 cycles, PhyStatus lanes0-3 staggered:
//    -> Rate=1, Ack high until lane3 status, rate_done once, cur_gen=2.
//  - target_gen=3 with MAX_GEN=2 -> rate_error next cycle, no Rate change.
//  - target_gen==cur_gen -> rate_done next cycle, tx_eidle_req never asserted.
//  - PclkChangeOk never asserts -> rate_error at TIMEOUT_CYCLES, Rate reverts to 0, cur_gen=1.
//  - Lane 2 PhyStatus pulses before ACK -> ignored; Ack held until lane 2 pulses again in ACK.

Source files
------------

// File: rtl/pipe_rate_change_ctrl.sv
// PIPE rate / PCLK change sequencer between the LTSSM and the PHY.
// Handles EIDLE, Rate/PCLKRate, PclkChangeOk/Ack, PhyStatus and timeout.
module pipe_rate_change_ctrl #(
  parameter int LANESNUMBER    = 16,
  parameter int MAX_GEN        = 1,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int EIDLE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   rate_req,
  input  logic [2:0]             target_gen,
  input  logic [LANESNUMBER-1:0] lane_mask,
  input  logic                   PclkChangeOk,
  input  logic [LANESNUMBER-1:0] PhyStatus,
  output logic [3:0]             Rate,
  output logic [4:0]             PCLKRate,
  output logic                   PclkChangeAck,
  output logic [1:0]             width,
  output logic                   tx_eidle_req,
  output logic                   busy,
  output logic                   rate_done,
  output logic                   rate_error,
  output logic [2:0]             cur_gen
);

  localparam int CMAX = (EIDLE_CYCLES > TIMEOUT_CYCLES) ?
                        EIDLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] E_LAST = CW'(EIDLE_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_SAT  = '1;
  localparam logic [2:0]    MAXG   = 3'(MAX_GEN);

  localparam logic [LANESNUMBER-1:0] LANE0 = LANESNUMBER'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EIDLE,
    S_SETRATE,
    S_ACK,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [2:0]             tgt_q, tgt_d;
  logic [2:0]             gen_q, gen_d;
  logic [LANESNUMBER-1:0] mask_q, mask_d;
  logic [LANESNUMBER-1:0] sticky_q, sticky_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [2:0]             drv_gen;
  logic                   in_flight;

  function automatic logic [1:0] wenc(input int w);
    case (w)
      16:      return 2'd1;
      32:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] gen_w(input logic [2:0] g);
    case (g)
      3'd2:    return wenc(GEN2_PIPEWIDTH);
      3'd3:    return wenc(GEN3_PIPEWIDTH);
      3'd4:    return wenc(GEN4_PIPEWIDTH);
      3'd5:    return wenc(GEN5_PIPEWIDTH);
      default: return wenc(GEN1_PIPEWIDTH);
    endcase
  endfunction

  // State and datapath registers; reset aborts any change in flight
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tgt_q    <= 3'd1;
      gen_q    <= 3'd1;
      mask_q   <= '0;
      sticky_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      gen_q    <= gen_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Sequencer: next state, counters, sticky PhyStatus and result pulses
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    gen_d    = gen_q;
    mask_d   = mask_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_inc  = (cnt_q == C_SAT) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (rate_req) begin
          if (target_gen == 3'd0 || target_gen > MAXG) begin
            err_d = 1'b1;
          end else if (target_gen == gen_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = target_gen;
            mask_d  = (lane_mask == '0) ? LANE0 : lane_mask;
            cnt_d   = '0;
            state_d = S_EIDLE;
          end
        end
      end
      S_EIDLE: begin
        if (cnt_q >= E_LAST) begin
          cnt_d   = '0;
          state_d = S_SETRATE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SETRATE: begin
        if (PclkChangeOk) begin
          cnt_d    = '0;
          sticky_d = '0;
          state_d  = S_ACK;
        end else if (cnt_q >= T_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACK: begin
        sticky_d = sticky_q | PhyStatus;
        if (&(sticky_d | ~mask_q)) begin
          gen_d   = tgt_q;
          state_d = S_DONE;
        end else if (cnt_q >= T_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PHY-facing rate follows the target only while the change is live
  always_comb begin
    in_flight = (state_q == S_SETRATE) || (state_q == S_ACK);
    drv_gen   = in_flight ? tgt_q : gen_q;
  end

  assign busy          = (state_q == S_EIDLE) || in_flight;
  assign tx_eidle_req  = busy;
  assign PclkChangeAck = (state_q == S_ACK);
  assign rate_done     = (state_q == S_DONE) || done_q;
  assign rate_error    = err_q;
  assign cur_gen       = gen_q;
  assign Rate          = {1'b0, drv_gen - 3'd1};
  assign PCLKRate      = {2'b00, drv_gen - 3'd1};
  assign width         = gen_w(drv_gen);

endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Bench for pipe_rate_change_ctrl: directed and random rate changes
// checked cycle by cycle against a phase-timing reference model.
module tb_pipe_rate_change_ctrl;

  localparam int E     = 8;
  localparam int T     = 40;
  localparam int N     = 16;
  localparam int MAXG  = 2;
  localparam int NEVER = 100000;

  logic          pclk = 1'b0;
  logic          reset_n;
  logic          rate_req;
  logic [2:0]    target_gen;
  logic [N-1:0]  lane_mask;
  logic          ok;
  logic [N-1:0]  phy;
  logic [3:0]    Rate;
  logic [4:0]    PCLKRate;
  logic          PclkChangeAck;
  logic [1:0]    width;
  logic          tx_eidle_req;
  logic          busy;
  logic          rate_done;
  logic          rate_error;
  logic [2:0]    cur_gen;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_m = 1;
  int pa[N];
  int pb[N];

  pipe_rate_change_ctrl #(
    .LANESNUMBER    (N),
    .MAX_GEN        (MAXG),
    .GEN1_PIPEWIDTH (8),
    .GEN2_PIPEWIDTH (16),
    .GEN3_PIPEWIDTH (8),
    .GEN4_PIPEWIDTH (8),
    .GEN5_PIPEWIDTH (8),
    .EIDLE_CYCLES   (E),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .pclk          (pclk),
    .reset_n       (reset_n),
    .rate_req      (rate_req),
    .target_gen    (target_gen),
    .lane_mask     (lane_mask),
    .PclkChangeOk  (ok),
    .PhyStatus     (phy),
    .Rate          (Rate),
    .PCLKRate      (PCLKRate),
    .PclkChangeAck (PclkChangeAck),
    .width         (width),
    .tx_eidle_req  (tx_eidle_req),
    .busy          (busy),
    .rate_done     (rate_done),
    .rate_error    (rate_error),
    .cur_gen       (cur_gen)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] wid(input int g);
    return (g == 2) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [18:0] obs();
    return {busy, tx_eidle_req, PclkChangeAck, rate_done, rate_error,
            Rate, PCLKRate, width, cur_gen};
  endfunction

  task automatic clr_pulses();
    for (int i = 0; i < N; i++) begin
      pa[i] = -1;
      pb[i] = -1;
    end
  endtask

  // One request at cycle 0; k = first cycle PclkChangeOk is high.
  task automatic run_txn(input int tgt, input logic [N-1:0] mask,
                         input int k);
    int          kind;
    int          endc;
    int          a;
    int          c0;
    int          f;
    int          t;
    int          drv;
    int          gen_e;
    bit          succ;
    bit          okf;
    bit          all_ok;
    bit          live;
    logic [N-1:0] m;
    logic [18:0] exp;
    succ = 0;
    okf  = 0;
    a    = 0;
    if (tgt < 1 || tgt > MAXG) begin
      kind = 0;
      endc = 1;
    end else if (tgt == cur_m) begin
      kind = 1;
      endc = 1;
      succ = 1;
    end else begin
      kind = 2;
      endc = E + T + 1;
      c0   = (k > E + 1) ? k : E + 1;
      if (c0 <= E + T) begin
        okf    = 1;
        a      = c0 + 1;
        m      = (mask == '0) ? 16'h0001 : mask;
        f      = a;
        all_ok = 1;
        for (int i = 0; i < N; i++) begin
          if (m[i]) begin
            if (pa[i] >= a) t = pa[i];
            else if (pb[i] >= a) t = pb[i];
            else t = -1;
            if (t < 0) all_ok = 0;
            else if (t > f) f = t;
          end
        end
        if (all_ok && f <= a + T - 1) begin
          succ = 1;
          endc = f + 1;
        end else begin
          endc = a + T;
        end
      end
    end
    for (int c = 0; c <= endc + 2; c++) begin
      @(posedge pclk);
      #1;
      rate_req   = (c == 0);
      target_gen = 3'(tgt);
      lane_mask  = mask;
      ok         = (c >= k);
      for (int i = 0; i < N; i++) phy[i] = (pa[i] == c) || (pb[i] == c);
      @(negedge pclk);
      live  = (kind == 2) && c >= 1 && c < endc;
      gen_e = (kind == 2 && succ && c >= endc) ? tgt : cur_m;
      drv   = (live && c >= E + 1) ? tgt : gen_e;
      exp   = {live, live,
               live && okf && c >= a,
               succ && c == endc,
               !succ && c == endc,
               4'(drv - 1), 5'(drv - 1), wid(drv), 3'(gen_e)};
      check($sformatf("trace g%0d->%0d c%0d", cur_m, tgt, c),
            32'(obs()), 32'(exp));
    end
    rate_req = 1'b0;
    ok       = 1'b0;
    phy      = '0;
    if (kind == 2 && succ) cur_m = tgt;
  endtask

  task automatic reset_mid_ack(input int tgt);
    bit seen;
    seen = 0;
    @(posedge pclk);
    #1;
    rate_req   = 1'b1;
    target_gen = 3'(tgt);
    lane_mask  = 16'h000F;
    ok         = 1'b1;
    phy        = '0;
    @(posedge pclk);
    #1;
    rate_req = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge pclk);
      seen = PclkChangeAck;
    end
    check("ack_reached", 32'(seen), 32'd1);
    @(posedge pclk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_rate", 32'(Rate), 32'd0);
    check("rst_ack", 32'(PclkChangeAck), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eidle", 32'(tx_eidle_req), 32'd0);
    check("rst_gen", 32'(cur_gen), 32'd1);
    ok = 1'b0;
    @(negedge pclk);
    reset_n = 1'b1;
    cur_m   = 1;
  endtask

  initial begin
    reset_n    = 1'b0;
    rate_req   = 1'b0;
    target_gen = 3'd0;
    lane_mask  = '0;
    ok         = 1'b0;
    phy        = '0;
    clr_pulses();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset_state", 32'(obs()), 32'({14'b0, 2'b00, 3'd1}));
    reset_n = 1'b1;

    run_txn(3, 16'h000F, 0);
    run_txn(0, 16'h000F, 0);
    run_txn(1, 16'h000F, 0);

    clr_pulses();
    for (int i = 0; i < 4; i++) pa[i] = E + 7 + 2 * i + 1;
    run_txn(2, 16'h000F, E + 6);
    check("gen_after_1to2", 32'(cur_gen), 32'd2);

    run_txn(2, 16'h00F0, 0);

    clr_pulses();
    pa[0] = E + 2;
    pa[1] = E + 2;
    pa[3] = E + 3;
    pa[2] = 3;
    pb[2] = E + 9;
    run_txn(1, 16'h000F, 0);

    run_txn(2, 16'h000F, NEVER);
    check("gen_after_ok_to", 32'(cur_gen), 32'd1);

    clr_pulses();
    run_txn(2, 16'h0003, 0);

    clr_pulses();
    pa[0] = E + 4;
    run_txn(2, 16'h0000, 0);

    for (int n = 0; n < 40; n++) begin
      int kk;
      logic [N-1:0] mk;
      for (int i = 0; i < N; i++) begin
        if ($urandom % 8 == 0) begin
          pa[i] = -1;
          pb[i] = -1;
        end else begin
          pa[i] = $urandom_range(0, E + 30);
          pb[i] = pa[i] + $urandom_range(1, 30);
        end
      end
      kk = ($urandom % 6 == 0) ? NEVER : $urandom_range(0, E + T + 5);
      mk = ($urandom % 5 == 0) ? '0 : 16'($urandom_range(1, 16'hFFFF));
      run_txn($urandom_range(0, 3), mk, kk);
    end

    clr_pulses();
    for (int i = 0; i < N; i++) pa[i] = E + 2;
    if (cur_m != 2) run_txn(2, 16'hFFFF, 0);
    reset_mid_ack(1);
    reset_mid_ack(2);
    run_txn(1, 16'h000F, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
